mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_CH, default 2, number of requester channels (ch 0 = IFU, ch 1 = LSU); legal 1..8.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; MASK_W = DATA_W/8 derived.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles waiting for a memory response; 0 disables the timeout.
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 ch_req_valid  input  N_CH  per-channel request valid.
REQ-008 ch_req_ready  output  N_CH  per-channel request accepted.
REQ-009 ch_addr  input  N_CH*ADDR_W  packed per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 ch_wen  input  N_CH  per-channel write enable (1 = write, 0 = read).
REQ-011 ch_wdata  input  N_CH*DATA_W  packed per-channel write data.
REQ-012 ch_wmask  input  N_CH*MASK_W  packed per-channel byte mask.
REQ-013 ch_resp_valid  output  N_CH  one-cycle response pulse to the owning channel.
REQ-014 ch_resp_err  output  1  response carries a timeout error; valid only with ch_resp_valid.
REQ-015 ch_rdata  output  DATA_W  shared response data bus; valid only with ch_resp_valid.
REQ-016 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream request handshake.
REQ-017 mem_addr, mem_wen, mem_wdata, mem_wmask  output  ADDR_W, 1, DATA_W, MASK_W  downstream request fields.
REQ-018 mem_resp_valid, mem_rdata  input  1, DATA_W  downstream response.
REQ-019 proto_err  output  1  sticky flag: mem_resp_valid seen outside WAIT.

Function
REQ-020 FSM states IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-021 IDLE: if any ch_req_valid, grant one channel round-robin, searching from pointer ptr upward with wrap; ch_req_ready is high only for the winner, only in IDLE, in that same cycle.
REQ-022 On grant: register addr/wen/wdata/wmask and owner id; ptr <= (owner+1) mod N_CH; next state REQ.
REQ-023 REQ: mem_req_valid=1, fields driven from registers and held stable until mem_req_ready; on the handshake cycle go to WAIT and clear the timeout counter.
REQ-024 WAIT: on mem_resp_valid, latch mem_rdata (force 0 if wen), err<=0, go to RESP.
REQ-025 WAIT timeout: counter increments each WAIT cycle; when it reaches TIMEOUT without a response, go to RESP with err=1 and rdata=0.
REQ-026 RESP: ch_resp_valid[owner]=1 for exactly one cycle, with ch_rdata and ch_resp_err; next state IDLE.
REQ-027 Minimum latency with mem_req_ready and mem_resp_valid asserted at first opportunity: grant at cycle 0, response pulse at cycle 3.
REQ-028 mem_resp_valid in IDLE/REQ/RESP is ignored for data and sets proto_err until reset.
REQ-029 Outside RESP, ch_resp_valid=0 and ch_rdata=0; outside REQ, mem_req_valid=0.
REQ-030 N_CH=1 is legal: the pointer is constant 0 and the arbitration is trivial.

Reset
REQ-031 On rst low, asynchronously: state=IDLE, ptr=0, counter=0, proto_err=0, and all outputs 0.
REQ-032 Reset mid-transaction abandons it without a response pulse; after reset release, the first grant goes to the lowest valid channel.

Structure
REQ-033 Shared package mem_arb_pkg holds the state enum and the owner-id width function clog2(N_CH) (minimum 1).
REQ-034 One sub-module rr_arbiter (N inputs, pointer in, one-hot grant out, purely combinational) performs the REQ-021 search.

Verification
REQ-035 Single read on ch0, addr 0x80000000, ready/resp immediate, mem_rdata 0xDEADBEEF -> ch_resp_valid=01 at cycle 3, rdata 0xDEADBEEF, err 0.
REQ-036 ch0 and ch1 valid continuously -> grants alternate 0,1,0,1; no channel is granted twice in a row.
REQ-037 Write on ch1, mask 4'b0011, wdata 0x12345678, mem_req_ready delayed 4 cycles -> mem fields stable for all 5 REQ cycles; response has rdata 0.
REQ-038 TIMEOUT=8, memory never responds -> response pulse with err=1, rdata=0, 8 cycles after entering WAIT; next request is accepted.
REQ-039 mem_resp_valid pulsed in IDLE -> proto_err=1 and stays 1; no ch_resp_valid.
REQ-040 rst low during WAIT -> outputs 0 immediately; a late mem_resp_valid after release sets proto_err and produces no response.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and sizing helper for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one so a
    // single-channel build still has a real owner/pointer register.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search from a start pointer
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Walk the requests starting at ptr and wrapping; the first hit wins.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-channel round-robin arbiter onto a single-outstanding memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            ch_req_valid,
    output logic [N_CH-1:0]            ch_req_ready,
    input  logic [N_CH*ADDR_W-1:0]     ch_addr,
    input  logic [N_CH-1:0]            ch_wen,
    input  logic [N_CH*DATA_W-1:0]     ch_wdata,
    input  logic [N_CH*(DATA_W/8)-1:0] ch_wmask,
    output logic [N_CH-1:0]            ch_resp_valid,
    output logic                       ch_resp_err,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_wen,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wmask,
    input  logic                       mem_resp_valid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       proto_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int ID_W   = clog2(N_CH);
    localparam int CNT_W  = clog2(TIMEOUT + 1);

    arb_state_t        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   gnt_idx;
    logic [N_CH-1:0]   gnt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    rr_arbiter #(
        .N     (N_CH),
        .PTR_W (ID_W)
    ) u_rr (
        .req   (ch_req_valid),
        .ptr   (ptr),
        .grant (gnt)
    );

    // Turn the one-hot grant into the owner index that gets registered.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx = ID_W'(i);
            end
        end
    end

    // Transaction FSM: grant, present request, wait for data or timeout, respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (mem_resp_valid && state != ST_WAIT) begin
                proto_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (|ch_req_valid) begin
                        owner   <= gnt_idx;
                        addr_q  <= ch_addr[gnt_idx*ADDR_W +: ADDR_W];
                        wen_q   <= ch_wen[gnt_idx];
                        wdata_q <= ch_wdata[gnt_idx*DATA_W +: DATA_W];
                        wmask_q <= ch_wmask[gnt_idx*MASK_W +: MASK_W];
                        ptr     <= ID_W'((int'(gnt_idx) + 1) % N_CH);
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= wen_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                        state   <= ST_RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is only offered to the winner while idle and out of reset.
    assign ch_req_ready  = (state == ST_IDLE && rst) ? gnt : '0;

    assign mem_req_valid = (state == ST_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ch_resp_valid = (state == ST_RESP) ? (N_CH'(1) << owner) : '0;
    assign ch_resp_err   = (state == ST_RESP) && err_q;
    assign ch_rdata      = (state == ST_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int N_CH   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int TMO    = 8;

    logic                     clk;
    logic                     rst;
    logic [N_CH-1:0]          ch_req_valid;
    logic [N_CH-1:0]          ch_req_ready;
    logic [N_CH*ADDR_W-1:0]   ch_addr;
    logic [N_CH-1:0]          ch_wen;
    logic [N_CH*DATA_W-1:0]   ch_wdata;
    logic [N_CH*MASK_W-1:0]   ch_wmask;
    logic [N_CH-1:0]          ch_resp_valid;
    logic                     ch_resp_err;
    logic [DATA_W-1:0]        ch_rdata;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_wen;
    logic [DATA_W-1:0]        mem_wdata;
    logic [MASK_W-1:0]        mem_wmask;
    logic                     mem_resp_valid;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     proto_err;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    mem_arbiter #(
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_req_valid   (ch_req_valid),
        .ch_req_ready   (ch_req_ready),
        .ch_addr        (ch_addr),
        .ch_wen         (ch_wen),
        .ch_wdata       (ch_wdata),
        .ch_wmask       (ch_wmask),
        .ch_resp_valid  (ch_resp_valid),
        .ch_resp_err    (ch_resp_err),
        .ch_rdata       (ch_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected response and compare it with the DUT outputs.
    task automatic sb_pop();
        exp_t e;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("resp_valid", 64'(ch_resp_valid), 64'(2'b01 << e.ch));
            check("resp_rdata", 64'(ch_rdata), 64'(e.rdata));
            check("resp_err",   64'(ch_resp_err), 64'(e.err));
        end
    endtask

    // One full transaction starting in IDLE; rsp_dly < 0 means memory never answers.
    task automatic txn(input logic [1:0] mask, input logic [1:0] exp_gnt,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic e_wen,
                       input logic [31:0] e_wdata, input logic [3:0] e_wmask,
                       input logic [31:0] e_rdata, input logic e_err, input logic keep);
        exp_t e;
        int   cyc;
        int   n;
        int   exp_lat;
        logic got;
        ch_req_valid = mask;
        #1;
        check("grant", 64'(ch_req_ready), 64'(exp_gnt));
        e.ch    = exp_gnt[1] ? 1 : 0;
        e.rdata = e_rdata;
        e.err   = e_err;
        exp_q.push_back(e);
        cyc = 0;
        tick();
        cyc++;
        if (!keep) ch_req_valid = '0;
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i == rdy_dly) mem_req_ready = 1'b1;
            #1;
            check("req_valid", 64'(mem_req_valid), 64'd1);
            check("req_addr",  64'(mem_addr), 64'(e_addr));
            check("req_wen",   64'(mem_wen), 64'(e_wen));
            check("req_wdata", 64'(mem_wdata), 64'(e_wdata));
            check("req_wmask", 64'(mem_wmask), 64'(e_wmask));
            check("ready_busy", 64'(ch_req_ready), 64'd0);
            tick();
            cyc++;
        end
        mem_req_ready = 1'b0;
        check("req_drop", 64'(mem_req_valid), 64'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (rsp_dly >= 0 && n == rsp_dly) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = rd;
            end
            tick();
            cyc++;
            n++;
            mem_resp_valid = 1'b0;
            if (ch_resp_valid != '0) got = 1'b1;
        end
        check("resp_seen", 64'(got), 64'd1);
        exp_lat = (rsp_dly >= 0) ? (2 + rdy_dly + rsp_dly + 1) : (2 + rdy_dly + TMO);
        check("resp_latency", 64'(cyc), 64'(exp_lat));
        if (got) sb_pop();
        if (keep) check("ready_resp", 64'(ch_req_ready), 64'd0);
        tick();
        check("resp_pulse_end", 64'(ch_resp_valid), 64'd0);
        check("rdata_idle", 64'(ch_rdata), 64'd0);
    endtask

    initial begin
        logic [1:0] prev_gnt;
        logic [1:0] alt_gnt [4];
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        ch_req_valid   = 2'b01;
        ch_addr        = '0;
        ch_wen         = '0;
        ch_wdata       = '0;
        ch_wmask       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        #12;
        check("rst_ready",     64'(ch_req_ready), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_resp",      64'(ch_resp_valid), 64'd0);
        check("rst_rdata",     64'(ch_rdata), 64'd0);
        check("rst_proto",     64'(proto_err), 64'd0);
        check("rst_addr",      64'(mem_addr), 64'd0);
        ch_req_valid = '0;
        tick();
        rst = 1'b1;
        tick();

        // Single read on channel 0 with immediate memory.
        ch_addr = {32'h0000_0000, 32'h8000_0000};
        ch_wen  = 2'b00;
        txn(2'b01, 2'b01, 0, 0, 32'hDEAD_BEEF, 32'h8000_0000, 1'b0, 32'h0, 4'h0,
            32'hDEAD_BEEF, 1'b0, 1'b0);

        // Write on channel 1, ready held off four cycles.
        ch_addr  = {32'h0000_4000, 32'h8000_0000};
        ch_wen   = 2'b10;
        ch_wdata = {32'h1234_5678, 32'h0};
        ch_wmask = {4'b0011, 4'b0000};
        txn(2'b10, 2'b10, 4, 1, 32'hCAFE_F00D, 32'h0000_4000, 1'b1, 32'h1234_5678, 4'b0011,
            32'h0, 1'b0, 1'b0);

        // Memory never answers: timeout response.
        ch_wen = 2'b00;
        ch_addr = {32'h0000_4000, 32'h0000_0100};
        txn(2'b01, 2'b01, 0, -1, 32'h0, 32'h0000_0100, 1'b0, 32'h0, 4'h0,
            32'h0, 1'b1, 1'b0);

        // Next request after the timeout still goes through.
        txn(2'b10, 2'b10, 1, 2, 32'h5555_AAAA, 32'h0000_4000, 1'b0, 32'h1234_5678, 4'b0011,
            32'h5555_AAAA, 1'b0, 1'b0);
        check("proto_clean", 64'(proto_err), 64'd0);

        // Stray response in IDLE.
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        check("proto_set",      64'(proto_err), 64'd1);
        check("proto_no_resp",  64'(ch_resp_valid), 64'd0);
        tick();
        tick();
        check("proto_sticky",   64'(proto_err), 64'd1);

        // Reset while waiting for memory, then a late response.
        ch_req_valid = 2'b10;
        tick();
        ch_req_valid  = 2'b00;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        ch_req_valid = 2'b11;
        #1;
        check("mid_rst_ready", 64'(ch_req_ready), 64'd0);
        check("mid_rst_memv",  64'(mem_req_valid), 64'd0);
        check("mid_rst_resp",  64'(ch_resp_valid), 64'd0);
        check("mid_rst_proto", 64'(proto_err), 64'd0);
        check("mid_rst_addr",  64'(mem_addr), 64'd0);
        ch_req_valid = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check("late_proto",   64'(proto_err), 64'd1);
        check("late_no_resp", 64'(ch_resp_valid), 64'd0);
        tick();
        check("late_no_resp2", 64'(ch_resp_valid), 64'd0);
        check("late_no_req",   64'(mem_req_valid), 64'd0);

        // Both channels continuously valid: first grant lowest, then alternate.
        ch_addr  = {32'h0000_2000, 32'h0000_1000};
        ch_wen   = 2'b10;
        ch_wdata = {32'hA5A5_A5A5, 32'h0};
        ch_wmask = {4'b1111, 4'b0000};
        alt_gnt[0] = 2'b01;
        alt_gnt[1] = 2'b10;
        alt_gnt[2] = 2'b01;
        alt_gnt[3] = 2'b10;
        prev_gnt = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (alt_gnt[k] == 2'b01) begin
                txn(2'b11, 2'b01, 0, 0, 32'h0BAD_0000 + 32'(k), 32'h0000_1000, 1'b0,
                    32'h0, 4'h0, 32'h0BAD_0000 + 32'(k), 1'b0, 1'b1);
            end else begin
                txn(2'b11, 2'b10, 0, 0, 32'h0BAD_0000 + 32'(k), 32'h0000_2000, 1'b1,
                    32'hA5A5_A5A5, 4'b1111, 32'h0, 1'b0, 1'b1);
            end
            if (k > 0) check("no_repeat", 64'(prev_gnt != alt_gnt[k]), 64'd1);
            prev_gnt = alt_gnt[k];
        end
        ch_req_valid = 2'b00;
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
